// File: rtl/frame_buf_pkg.sv
// Shared types and geometry for the double-buffered HUB75 frame store.
package frame_buf_pkg;

  localparam int COLS   = 64;
  localparam int ROWS   = 32;
  localparam int PIX_W  = 12;
  localparam int ADDR_W = 10;
  localparam int NPIX   = COLS * ROWS;

  typedef logic [PIX_W-1:0] pixel_t;
  typedef logic [ADDR_W:0]  wr_idx_t;

  typedef enum logic [1:0] {FILL, FULL, SWAP} fb_state_t;

  localparam wr_idx_t LAST_IDX = wr_idx_t'(NPIX - 1);

endpackage

// File: rtl/frame_buf_if.sv
// Renderer-to-frame-buffer pixel stream (valid/ready with end-of-frame marker).
interface frame_buf_if
  import frame_buf_pkg::*;
();

  logic   wr_valid;
  logic   wr_ready;
  pixel_t wr_data;
  logic   wr_last;

  modport master (output wr_valid, output wr_data, output wr_last, input wr_ready);
  modport slave  (input wr_valid, input wr_data, input wr_last, output wr_ready);

endinterface

// File: rtl/frame_buf_ram.sv
// Simple dual-port RAM: one write port, one registered read port.
// Contents are not reset; only the read register clears.
module sdp_ram #(
  parameter int AW = 11,
  parameter int DW = 12
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [0:(1<<AW)-1];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) rdata <= '0;
    else      rdata <= mem[raddr];
  end

endmodule

// File: rtl/frame_buf.sv
// Double-buffered RGB444 pixel store: renderer fills the back buffer,
// display reads the front buffer, buffers swap only on frame_sync.
module frame_buf
  import frame_buf_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  frame_buf_if.slave        wr,
  input  logic              frame_sync,
  input  logic [ADDR_W-1:0] r_addr,
  output pixel_t            din_top,
  output pixel_t            din_btm,
  output logic              front_sel,
  output logic              swapped,
  output logic              fmt_err
);

  fb_state_t state;
  wr_idx_t   wr_cnt;

  logic            accept;
  logic            at_last;
  logic            we_top;
  logic            we_btm;
  logic [ADDR_W:0] waddr;
  logic [ADDR_W:0] raddr;

  assign accept  = wr.wr_valid && wr.wr_ready;
  assign at_last = (wr_cnt == LAST_IDX);
  assign we_top  = accept && !wr_cnt[ADDR_W];
  assign we_btm  = accept &&  wr_cnt[ADDR_W];
  // Buffer index is the RAM address MSB; writes always go to the back buffer.
  assign waddr   = {~front_sel, wr_cnt[ADDR_W-1:0]};
  assign raddr   = {front_sel, r_addr};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= FILL;
      wr_cnt      <= '0;
      front_sel   <= 1'b0;
      swapped     <= 1'b0;
      fmt_err     <= 1'b0;
      wr.wr_ready <= 1'b0;
    end else begin
      swapped <= 1'b0;
      case (state)
        FILL: begin
          wr.wr_ready <= 1'b1;
          if (accept) begin
            if (at_last) begin
              state       <= FULL;
              wr_cnt      <= '0;
              wr.wr_ready <= 1'b0;
              if (!wr.wr_last) fmt_err <= 1'b1;
            end else if (wr.wr_last) begin
              // Short frame: drop it and restart at pixel 0 without swapping.
              wr_cnt  <= '0;
              fmt_err <= 1'b1;
            end else begin
              wr_cnt <= wr_cnt + 1'b1;
            end
          end
        end
        FULL: begin
          wr.wr_ready <= 1'b0;
          if (frame_sync) state <= SWAP;
        end
        SWAP: begin
          front_sel   <= ~front_sel;
          swapped     <= 1'b1;
          wr.wr_ready <= 1'b1;
          state       <= FILL;
        end
        default: state <= FILL;
      endcase
    end
  end

  sdp_ram #(.AW(ADDR_W+1), .DW(PIX_W)) u_ram_top (
    .clk   (clk),
    .rst   (rst),
    .we    (we_top),
    .waddr (waddr),
    .wdata (wr.wr_data),
    .raddr (raddr),
    .rdata (din_top)
  );

  sdp_ram #(.AW(ADDR_W+1), .DW(PIX_W)) u_ram_btm (
    .clk   (clk),
    .rst   (rst),
    .we    (we_btm),
    .waddr (waddr),
    .wdata (wr.wr_data),
    .raddr (raddr),
    .rdata (din_btm)
  );

endmodule

// File: tb/tb_frame_buf.sv
// Directed bench for frame_buf with a shadow model of both buffers and a
// read scoreboard.
module tb_frame_buf;
  import frame_buf_pkg::*;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              frame_sync = 1'b0;
  logic [ADDR_W-1:0] r_addr = '0;
  pixel_t            din_top, din_btm;
  logic              front_sel, swapped, fmt_err;

  frame_buf_if wif();

  frame_buf dut (
    .clk        (clk),
    .rst        (rst),
    .wr         (wif.slave),
    .frame_sync (frame_sync),
    .r_addr     (r_addr),
    .din_top    (din_top),
    .din_btm    (din_btm),
    .front_sel  (front_sel),
    .swapped    (swapped),
    .fmt_err    (fmt_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    pixel_t top;
    pixel_t btm;
    int     addr;
  } rd_exp_t;

  rd_exp_t sbq[$];
  pixel_t  model_top [0:2*1024-1];
  pixel_t  model_btm [0:2*1024-1];

  int   total = 0;
  int   bad = 0;
  logic exp_front = 1'b0;
  int   exp_cnt = 0;
  logic exp_fmt = 1'b0;
  int   not_ready = 0;
  int   swap_seen = 0;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (swapped === 1'b1) swap_seen++;
  endtask

  function automatic pixel_t pixel_for(input int kind, input int p);
    case (kind)
      0:       return pixel_t'(p);
      1:       return pixel_t'(p * 7 + 3);
      2:       return pixel_t'(p ^ 'h5A5);
      3:       return pixel_t'(~p);
      default: return pixel_t'(p * 13 + 1);
    endcase
  endfunction

  // Drive one pixel for one cycle and update the shadow buffers as if accepted.
  task automatic applyStimulus(input pixel_t d, input logic last, input logic sync);
    int back;
    int a;
    wif.wr_valid = 1'b1;
    wif.wr_data  = d;
    wif.wr_last  = last;
    frame_sync   = sync;
    if (wif.wr_ready !== 1'b1) not_ready++;
    back = exp_front ? 0 : 1;
    a    = back * 1024 + (exp_cnt % 1024);
    if (exp_cnt >= 1024) model_btm[a] = d;
    else                 model_top[a] = d;
    if (exp_cnt == NPIX - 1) begin
      exp_cnt = 0;
      if (!last) exp_fmt = 1'b1;
    end else if (last) begin
      exp_cnt = 0;
      exp_fmt = 1'b1;
    end else begin
      exp_cnt++;
    end
    tick();
    wif.wr_valid = 1'b0;
    wif.wr_last  = 1'b0;
    frame_sync   = 1'b0;
  endtask

  task automatic send_frame(input int n, input int kind, input int last_at, input int sync_at);
    for (int p = 0; p < n; p++)
      applyStimulus(pixel_for(kind, p), p == last_at, p == sync_at);
  endtask

  task automatic read_check(input int addr);
    rd_exp_t e;
    int idx;
    r_addr = addr[ADDR_W-1:0];
    idx = (exp_front ? 1024 : 0) + addr;
    e.top = model_top[idx];
    e.btm = model_btm[idx];
    e.addr = addr;
    sbq.push_back(e);
    tick();
    e = sbq.pop_front();
    checkOutput($sformatf("din_top@%0d", e.addr), 32'(din_top), 32'(e.top));
    checkOutput($sformatf("din_btm@%0d", e.addr), 32'(din_btm), 32'(e.btm));
  endtask

  task automatic expect_swap(input string tag);
    logic got;
    got = 1'b0;
    frame_sync = 1'b1;
    tick();
    frame_sync = 1'b0;
    for (int i = 0; i < 8 && !got; i++) begin
      tick();
      if (swapped === 1'b1) got = 1'b1;
    end
    checkOutput({tag, "_swapped"}, 32'(got), 32'd1);
    exp_front = ~exp_front;
    checkOutput({tag, "_front_sel"}, 32'(front_sel), 32'(exp_front));
    tick();
    checkOutput({tag, "_swap_pulse_end"}, 32'(swapped), 32'd0);
    checkOutput({tag, "_ready_after_swap"}, 32'(wif.wr_ready), 32'd1);
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int ready_high;
    for (int i = 0; i < 2048; i++) begin
      model_top[i] = '0;
      model_btm[i] = '0;
    end
    wif.wr_valid = 1'b0;
    wif.wr_data  = '0;
    wif.wr_last  = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_wr_ready", 32'(wif.wr_ready), 32'd0);
    checkOutput("rst_front_sel", 32'(front_sel), 32'd0);
    checkOutput("rst_din_top", 32'(din_top), 32'd0);
    checkOutput("rst_din_btm", 32'(din_btm), 32'd0);
    checkOutput("rst_fmt_err", 32'(fmt_err), 32'd0);
    checkOutput("rst_swapped", 32'(swapped), 32'd0);
    rst = 1'b1;
    tick();
    checkOutput("release_wr_ready", 32'(wif.wr_ready), 32'd1);

    // Full frame with an early frame_sync at pixel 1000
    not_ready = 0;
    swap_seen = 0;
    send_frame(NPIX, 0, NPIX - 1, 1000);
    checkOutput("frameA_not_ready", 32'(not_ready), 32'd0);
    checkOutput("frameA_early_sync_swaps", 32'(swap_seen), 32'd0);
    checkOutput("frameA_front_sel", 32'(front_sel), 32'd0);
    checkOutput("frameA_fmt_err", 32'(fmt_err), 32'(exp_fmt));

    // Backpressure while full
    ready_high = 0;
    wif.wr_valid = 1'b1;
    wif.wr_data  = 12'hABC;
    repeat (500) begin
      tick();
      if (wif.wr_ready !== 1'b0) ready_high++;
    end
    wif.wr_valid = 1'b0;
    checkOutput("full_ready_high_cycles", 32'(ready_high), 32'd0);
    checkOutput("full_no_swap", 32'(swap_seen), 32'd0);

    expect_swap("swapA");
    checkOutput("swapA_const_front", 32'(front_sel), 32'd1);
    read_check(5);
    read_check(0);
    read_check(1023);
    read_check(777);

    // Early wr_last at pixel 100
    send_frame(101, 2, 100, -1);
    checkOutput("early_last_fmt_err", 32'(fmt_err), 32'd1);
    checkOutput("early_last_ready", 32'(wif.wr_ready), 32'd1);
    swap_seen = 0;
    frame_sync = 1'b1;
    tick();
    frame_sync = 1'b0;
    repeat (5) tick();
    checkOutput("early_last_no_swap", 32'(swap_seen), 32'd0);
    checkOutput("early_last_front", 32'(front_sel), 32'(exp_front));

    // Correct frame; frame_sync coincides with the final write and must be ignored
    not_ready = 0;
    send_frame(NPIX, 1, NPIX - 1, NPIX - 1);
    checkOutput("frameB_not_ready", 32'(not_ready), 32'd0);
    swap_seen = 0;
    repeat (5) tick();
    checkOutput("frameB_sync_on_last_no_swap", 32'(swap_seen), 32'd0);
    checkOutput("frameB_full_ready", 32'(wif.wr_ready), 32'd0);
    checkOutput("frameB_fmt_sticky", 32'(fmt_err), 32'(exp_fmt));
    expect_swap("swapB");
    read_check(0);
    read_check(100);
    read_check(1023);
    read_check(3);

    // Mid-frame reset at pixel 1500
    send_frame(1500, 3, -1, -1);
    rst = 1'b0;
    #1;
    exp_front = 1'b0;
    exp_cnt   = 0;
    exp_fmt   = 1'b0;
    checkOutput("midrst_front_sel", 32'(front_sel), 32'd0);
    checkOutput("midrst_wr_ready", 32'(wif.wr_ready), 32'd0);
    checkOutput("midrst_fmt_err", 32'(fmt_err), 32'd0);
    checkOutput("midrst_din_top", 32'(din_top), 32'd0);
    tick();
    rst = 1'b1;
    tick();
    checkOutput("midrst_release_ready", 32'(wif.wr_ready), 32'd1);
    read_check(3);
    read_check(1023);

    not_ready = 0;
    send_frame(NPIX, 4, NPIX - 1, -1);
    checkOutput("frameC_not_ready", 32'(not_ready), 32'd0);
    expect_swap("swapC");
    read_check(0);
    read_check(1499 % 1024);
    read_check(1023);
    read_check(600);
    checkOutput("frameC_fmt_err", 32'(fmt_err), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
